// File: rtl/icache_fetch_pkg.sv
// icache_pkg: shared definitions for the icache_fetch block.
//   - default cache geometry and the address field widths derived from it
//   - refill controller state encoding
//   - split_addr(): breaks a byte address into tag / index / word offset
package icache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 4;

  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILLED = 2'd2
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
  } addr_fields_t;

  // Bits [1:0] are the byte-in-word position and are not part of any field.
  function automatic addr_fields_t split_addr(input logic [DEF_ADDR_W-1:0] addr);
    addr_fields_t f;
    f.offset = addr[2 +: OFF_W];
    f.index  = addr[2 + OFF_W +: IDX_W];
    f.tag    = addr[DEF_ADDR_W-1 -: TAG_W];
    return f;
  endfunction

endpackage

// File: rtl/icache_fetch_if.sv
// icache_fetch_if: fetch-side and memory-side signals of the instruction cache.
//   slave  : the cache's view (takes fetch requests and refill data,
//            drives instr/hit/stall and the refill request)
//   master : the environment's view (fetch stage plus instruction memory)
// Signals:
//   pc_req, pc_addr, flush      fetch request and cache invalidate
//   instr, hit, stall           fetch response
//   mem_req, mem_addr           refill word request, held until accepted
//   mem_rdata, mem_valid        refill data, mem_valid accepts mem_req
interface icache_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              pc_req;
  logic [ADDR_W-1:0] pc_addr;
  logic              flush;
  logic [31:0]       instr;
  logic              hit;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_valid;

  modport slave (
    input  pc_req, pc_addr, flush, mem_rdata, mem_valid,
    output instr, hit, stall, mem_req, mem_addr
  );

  modport master (
    output pc_req, pc_addr, flush, mem_rdata, mem_valid,
    input  instr, hit, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_tag_array.sv
// icache_tag_array: valid bits and tags of the direct-mapped cache.
// Ports:
//   clk, rst                    clock, synchronous active-high reset (clears valid)
//   lookup_index, lookup_tag    combinational lookup, lookup_hit = valid && tag match
//   set_en, set_index, set_tag  mark a line valid with a new tag at the clock edge
//   flush_all                   clear every valid bit at the clock edge
module icache_tag_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_index,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             flush_all
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];

  assign lookup_hit = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);

  // Flush is applied after the set so a flush coinciding with a line
  // completion leaves that line invalid as well.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (set_en) begin
      valid_d[set_index] = 1'b1;
      tag_d[set_index]   = set_tag;
    end
    if (flush_all) begin
      valid_d = '0;
    end
  end

  // Tags need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    tag_q <= tag_d;
  end

endmodule

// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, read-only instruction cache in front of fetch.
// Hits are served combinationally; a miss raises stall, refills the whole
// line word by word from instruction memory, spends one FILLED cycle, and
// then the request is looked up again.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        icache_fetch_if.slave: fetch request/response and refill bus
module icache_fetch
  import icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS
) (
  input logic           clk,
  input logic           rst,
  icache_fetch_if.slave bus
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;

  logic [TAG_BITS-1:0] pc_tag;
  logic [IDX_BITS-1:0] pc_index;
  logic [OFF_BITS-1:0] pc_offset;
  logic                unused_byte_bits;

  assign pc_offset        = bus.pc_addr[2 +: OFF_BITS];
  assign pc_index         = bus.pc_addr[2 + OFF_BITS +: IDX_BITS];
  assign pc_tag           = bus.pc_addr[ADDR_W-1 -: TAG_BITS];
  assign unused_byte_bits = ^bus.pc_addr[1:0];

  state_e              state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic [TAG_BITS-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_BITS-1:0] miss_index_q, miss_index_d;
  logic [31:0]         data_q [LINES][WORDS];
  logic [31:0]         data_d [LINES][WORDS];

  logic lookup_hit;
  logic set_en;
  logic flush_all;
  logic fill_we;

  icache_tag_array #(
    .LINES (LINES),
    .IDX_W (IDX_BITS),
    .TAG_W (TAG_BITS)
  ) u_tags (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (pc_index),
    .lookup_tag   (pc_tag),
    .lookup_hit   (lookup_hit),
    .set_en       (set_en),
    .set_index    (miss_index_q),
    .set_tag      (miss_tag_q),
    .flush_all    (flush_all)
  );

  // Refill controller: next state, refill bookkeeping and all fetch/memory
  // outputs. The refill address comes from the latched miss, so a pc_addr
  // change during the stall cannot redirect a line fill in progress.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    set_en       = 1'b0;
    flush_all    = 1'b0;
    fill_we      = 1'b0;
    bus.hit      = 1'b0;
    bus.stall    = 1'b0;
    bus.instr    = '0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;

    unique case (state_q)
      IDLE: begin
        abort_d   = 1'b0;
        flush_all = bus.flush;
        if (bus.pc_req) begin
          if (lookup_hit) begin
            bus.hit   = 1'b1;
            bus.instr = data_q[pc_index][pc_offset];
          end else begin
            bus.stall    = 1'b1;
            miss_tag_d   = pc_tag;
            miss_index_d = pc_index;
            cnt_d        = '0;
            state_d      = REFILL;
          end
        end
      end

      REFILL: begin
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
        // A flush here must not stop the fill (memory would still answer),
        // it only prevents the line from being validated.
        if (bus.flush) begin
          flush_all = 1'b1;
          abort_d   = 1'b1;
        end
        if (bus.mem_valid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_BITS'(WORDS - 1)) begin
            set_en  = !abort_q && !bus.flush;
            state_d = FILLED;
          end
        end
      end

      FILLED: begin
        bus.stall = 1'b1;
        flush_all = bus.flush;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Data storage: one refill word written per accepted memory beat.
  always_comb begin
    data_d = data_q;
    if (fill_we) begin
      data_d[miss_index_q][cnt_q] = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Serves 32-bit instructions to fetch and drives the `hit` qualifier that fetch forwards into the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- On a miss it raises `stall`, refills one line from backing instruction memory over a req/valid handshake, then serves the request.

Parameters:
- ADDR_W, 32, byte address width.
- LINES, 16, number of lines (power of 2).
- WORDS, 4, 32-bit words per line (power of 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_req  in  1  fetch requests the instruction at pc_addr this cycle
- pc_addr  in  ADDR_W  byte address; bits [1:0] ignored
- flush  in  1  invalidate the entire cache
- instr  out  32  instruction; valid only when hit=1
- hit  out  1  pc_req AND lookup hit, in the same cycle
- stall  out  1  fetch must hold pc_addr and must not advance
- mem_req  out  1  refill word request, held until accepted
- mem_addr  out  ADDR_W  word-aligned refill address
- mem_rdata  in  32  refill data
- mem_valid  in  1  mem_rdata valid; accepts the current mem_req

Behaviour:
- Address split for defaults:
  - offset = [3:2]
  - index = [7:4]
  - tag = [31:8]
  - Widths derive from $clog2(WORDS) and $clog2(LINES).
- Storage: valid[LINES], tag[LINES], data[LINES][WORDS], all flops. Lookup is combinational, so a hit is served with zero latency.
- Reset: all valid bits = 0, state = IDLE, word counter = 0, abort flag = 0. mem_req = 0, mem_addr = 0, stall = 0, hit = 0, instr = 0.
- State IDLE:
  - pc_req=1 with valid && tag match: hit=1, instr = data[index][offset], stall=0.
  - pc_req=1 with a miss: hit=0, stall=1 in the same cycle. Latch the miss address's tag and index, clear the counter, go to REFILL.
  - pc_req=0: hit=0, stall=0, no state change.
- State REFILL:
  - stall=1, hit=0, mem_req=1, mem_addr = {tag, index, counter, 2'b00}.
  - On mem_valid: write mem_rdata into data[index][counter], counter += 1. mem_addr advances on the following cycle.
  - mem_valid arriving in the same cycle as a new request is legal (0-wait memory).
  - On the mem_valid of the last word (counter == WORDS-1): mem_req drops the next cycle. Set valid[index] and tag[index] unless the abort flag is set. Go to FILLED.
- State FILLED:
  - Lasts one cycle, stall=1, then returns to IDLE.
  - IDLE re-runs the lookup on the current pc_addr. It hits if pc_addr is unchanged.
- Line fill order is sequential from word 0 with no critical-word-first; the miss penalty is WORDS × memory latency + 2 cycles.
- mem_valid while mem_req=0 is ignored.
- Fetch holds pc_addr while stall=1. If pc_addr changes anyway, the refill completes for the latched line and the new address is looked up in IDLE.
- flush:
  - In IDLE, all valid bits are cleared at the clock edge. Lookup in the flush cycle still uses pre-flush state.
  - In REFILL, all valid bits are cleared and the abort flag is set. The refill runs to completion so no orphan mem_valid occurs, but the line is not validated. The abort flag clears on entry to IDLE.
- rst mid-refill: immediate return to IDLE, mem_req=0 next cycle. Memory must tolerate the abandoned request.
- A refill overwrites a valid line at the same index (conflict eviction). No write path and no dirty state exist.

Decomposition:
- Shared package icache_pkg holds:
  - state enum {IDLE, REFILL, FILLED};
  - localparams OFF_W, IDX_W, TAG_W derived from the parameters;
  - a function splitting an address into tag/index/offset.
- One natural sub-module, icache_tag_array, holds the valid and tag flops with lookup compare, set and flush-all.

Test Plan:
- Cold miss: after rst, pc_req=1, pc_addr=0x0000_0040, memory latency 3 with rdata=addr^0xA5A5_0000.
  - stall=1 for 4×3+2 cycles.
  - mem_addr sequence is 0x40, 0x44, 0x48, 0x4C.
  - Then hit=1, instr=0xA5A5_0040.
- Line reuse: pc_addr=0x44, 0x48, 0x4C back-to-back after the above. hit=1 each cycle, stall=0, mem_req never asserted.
- Conflict: access 0x40, then 0x140 (same index 4, different tag), then 0x40 again. Three refills, and the last returns 0xA5A5_0040.
- Flush: with line 0x40 valid, pulse flush, then fetch 0x40. Miss and a full refill.
- Flush mid-refill: flush on the 2nd mem_valid. All 4 words are still fetched, valid[4] stays 0, and the subsequent lookup of 0x40 misses again.
- Reset mid-refill: rst after the first mem_valid. Next cycle mem_req=0, stall=0, hit=0, and a lookup of 0x40 misses.
